// File: rtl/datapath_pkg.sv
// Shared constants and ALU operation encoding for the single-bus datapath.
// Used by datapath and datapath_alu.
package datapath_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_INC,
    OP_MUL,
    OP_DIV
  } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A=Y, B=bus; priority DIV > MUL > IncPC > add.
// Divider is present only when DATAPATH_DIV_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               div,
  input  logic               mul,
  input  logic               inc_pc,
  output logic [2*WIDTH-1:0] result
);

  alu_op_e            op;
  logic [WIDTH-1:0]   sum_val;
  logic [WIDTH-1:0]   inc_val;
  logic [2*WIDTH-1:0] prod;

  assign sum_val = a + b;
  assign inc_val = b + WIDTH'(1);
  // Operands sign-extended to full width so the low 2*WIDTH bits are the signed product.
  assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

`ifdef DATAPATH_DIV_EN
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_comb begin
    quot = '1;
    rem  = a;
    if (b != '0) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end
`else
  logic unused_div;
  assign unused_div = div;
`endif

  always_comb begin
    op = OP_ADD;
    if (inc_pc) op = OP_INC;
    if (mul)    op = OP_MUL;
`ifdef DATAPATH_DIV_EN
    if (div)    op = OP_DIV;
`endif
  end

  always_comb begin
    result = {{WIDTH{1'b0}}, sum_val};
    case (op)
      OP_INC:  result = {{WIDTH{1'b0}}, inc_val};
      OP_MUL:  result = prod;
`ifdef DATAPATH_DIV_EN
      OP_DIV:  result = {rem, quot};
`endif
      default: result = {{WIDTH{1'b0}}, sum_val};
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: registers, priority bus mux and ALU instance.
// Optional divider enabled by defining DATAPATH_DIV_EN.
module datapath
  import datapath_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               PCout,
  input  logic               Zlowout,
  input  logic               Zhighout,
  input  logic               MDRout,
  input  logic               R2out,
  input  logic               R4out,
  input  logic               PCin,
  input  logic               MARin,
  input  logic               MDRin,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               Zin,
  input  logic               HIin,
  input  logic               LOin,
  input  logic               R2in,
  input  logic               R4in,
  input  logic               R5in,
  input  logic               IncPC,
  input  logic               MUL,
  input  logic               DIV,
  input  logic               read,
  input  logic [WIDTH-1:0]   Mdatain,
  output logic [WIDTH-1:0]   R0,
  output logic [WIDTH-1:0]   R1,
  output logic [WIDTH-1:0]   R2,
  output logic [WIDTH-1:0]   R3,
  output logic [WIDTH-1:0]   R4,
  output logic [WIDTH-1:0]   R5,
  output logic [WIDTH-1:0]   R6,
  output logic [WIDTH-1:0]   R7,
  output logic [WIDTH-1:0]   R8,
  output logic [WIDTH-1:0]   R9,
  output logic [WIDTH-1:0]   R10,
  output logic [WIDTH-1:0]   R11,
  output logic [WIDTH-1:0]   R12,
  output logic [WIDTH-1:0]   R13,
  output logic [WIDTH-1:0]   R14,
  output logic [WIDTH-1:0]   R15,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic [WIDTH-1:0]   MDR,
  output logic [WIDTH-1:0]   IR,
  output logic [2*WIDTH-1:0] Z,
  output logic [2*WIDTH-1:0] ALUout,
  output logic [WIDTH-1:0]   bus_mux_out
);

  logic [WIDTH-1:0]   pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, hi_reg, lo_reg;
  logic [WIDTH-1:0]   r2_reg, r4_reg, r5_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   mdr_next;
  logic [2*WIDTH-1:0] alu_result;

  // MAR feeds the memory address path, which lies outside this block.
  logic unused_mar;
  assign unused_mar = ^mar_reg;

  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr_reg;
    else if (PCout)    bus = pc_reg;
    else if (Zlowout)  bus = z_reg[WIDTH-1:0];
    else if (Zhighout) bus = z_reg[2*WIDTH-1:WIDTH];
    else if (R2out)    bus = r2_reg;
    else if (R4out)    bus = r4_reg;
  end

  assign mdr_next = read ? Mdatain : bus;

  datapath_alu u_alu (
    .a      (y_reg),
    .b      (bus),
    .div    (DIV),
    .mul    (MUL),
    .inc_pc (IncPC),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_reg  <= '0;
      ir_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
      y_reg   <= '0;
      z_reg   <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      r2_reg  <= '0;
      r4_reg  <= '0;
      r5_reg  <= '0;
    end else begin
      if (PCin)  pc_reg  <= bus;
      if (IRin)  ir_reg  <= bus;
      if (MARin) mar_reg <= bus;
      if (MDRin) mdr_reg <= mdr_next;
      if (Yin)   y_reg   <= bus;
      if (Zin)   z_reg   <= alu_result;
      if (HIin)  hi_reg  <= bus;
      if (LOin)  lo_reg  <= bus;
      if (R2in)  r2_reg  <= bus;
      if (R4in)  r4_reg  <= bus;
      if (R5in)  r5_reg  <= bus;
    end
  end

  assign R0  = '0;
  assign R1  = '0;
  assign R2  = r2_reg;
  assign R3  = '0;
  assign R4  = r4_reg;
  assign R5  = r5_reg;
  assign R6  = '0;
  assign R7  = '0;
  assign R8  = '0;
  assign R9  = '0;
  assign R10 = '0;
  assign R11 = '0;
  assign R12 = '0;
  assign R13 = '0;
  assign R14 = '0;
  assign R15 = '0;

  assign Hi          = hi_reg;
  assign Lo          = lo_reg;
  assign MDR         = mdr_reg;
  assign IR          = ir_reg;
  assign Z           = z_reg;
  assign ALUout      = alu_result;
  assign bus_mux_out = bus;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed vector table, async reset, then
// randomized cycles against an arithmetic reference model.
module tb_datapath;

`ifdef DATAPATH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [20:0] M_PCOUT  = 21'h000001;
  localparam logic [20:0] M_ZLO    = 21'h000002;
  localparam logic [20:0] M_ZHI    = 21'h000004;
  localparam logic [20:0] M_MDROUT = 21'h000008;
  localparam logic [20:0] M_R2OUT  = 21'h000010;
  localparam logic [20:0] M_R4OUT  = 21'h000020;
  localparam logic [20:0] M_PCIN   = 21'h000040;
  localparam logic [20:0] M_MARIN  = 21'h000080;
  localparam logic [20:0] M_MDRIN  = 21'h000100;
  localparam logic [20:0] M_IRIN   = 21'h000200;
  localparam logic [20:0] M_YIN    = 21'h000400;
  localparam logic [20:0] M_ZIN    = 21'h000800;
  localparam logic [20:0] M_HIIN   = 21'h001000;
  localparam logic [20:0] M_LOIN   = 21'h002000;
  localparam logic [20:0] M_R2IN   = 21'h004000;
  localparam logic [20:0] M_R4IN   = 21'h008000;
  localparam logic [20:0] M_R5IN   = 21'h010000;
  localparam logic [20:0] M_INC    = 21'h020000;
  localparam logic [20:0] M_MUL    = 21'h040000;
  localparam logic [20:0] M_DIV    = 21'h080000;
  localparam logic [20:0] M_READ   = 21'h100000;

  localparam int K_NONE = 0, K_MDR = 1, K_R2 = 2, K_R4 = 3, K_R5 = 4, K_IR = 5,
                 K_Z = 6, K_HI = 7, K_LO = 8, K_BUS = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;
  logic PCout, Zlowout, Zhighout, MDRout, R2out, R4out;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, R2in, R4in, R5in;
  logic IncPC, MUL, DIV, read;
  logic [31:0] Mdatain;
  logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] Hi, Lo, MDR, IR, bus_mux_out;
  logic [63:0] Z, ALUout;

  datapath dut (
    .clk(clk), .clr(clr),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .R2in(R2in), .R4in(R4in), .R5in(R5in),
    .IncPC(IncPC), .MUL(MUL), .DIV(DIV), .read(read), .Mdatain(Mdatain),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14), .R15(R15),
    .Hi(Hi), .Lo(Lo), .MDR(MDR), .IR(IR), .Z(Z), .ALUout(ALUout),
    .bus_mux_out(bus_mux_out)
  );

  typedef struct {
    logic [20:0] ctl;
    logic [31:0] mdat;
    int          kind;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_r2, m_r4, m_r5;
  logic [63:0] m_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [20:0] c, input logic [31:0] md);
    PCout = c[0];  Zlowout = c[1]; Zhighout = c[2]; MDRout = c[3];
    R2out = c[4];  R4out = c[5];   PCin = c[6];     MARin = c[7];
    MDRin = c[8];  IRin = c[9];    Yin = c[10];     Zin = c[11];
    HIin = c[12];  LOin = c[13];   R2in = c[14];    R4in = c[15];
    R5in = c[16];  IncPC = c[17];  MUL = c[18];     DIV = c[19];
    read = c[20];  Mdatain = md;
  endtask

  function automatic void add_vec(input logic [20:0] c, input logic [31:0] md,
                                  input int k, input logic [63:0] e, input string n);
    vec_t v;
    v.ctl = c; v.mdat = md; v.kind = k; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic logic [63:0] observe(input int k);
    case (k)
      K_MDR:   return {32'h0, MDR};
      K_R2:    return {32'h0, R2};
      K_R4:    return {32'h0, R4};
      K_R5:    return {32'h0, R5};
      K_IR:    return {32'h0, IR};
      K_Z:     return Z;
      K_HI:    return {32'h0, Hi};
      K_LO:    return {32'h0, Lo};
      default: return {32'h0, bus_mux_out};
    endcase
  endfunction

  // ALU reference computed with 64-bit signed arithmetic.
  function automatic logic [63:0] ref_alu(input logic [31:0] y, input logic [31:0] b,
                                          input logic d, input logic m, input logic i);
    longint sa, sb, q, r, p;
    sa = longint'($signed(y));
    sb = longint'($signed(b));
    if (d && DIV_EN) begin
      if (b == 32'h0) return {y, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (m) begin
      p = sa * sb;
      return p;
    end
    if (i) return {32'h0, b + 32'd1};
    return {32'h0, y + b};
  endfunction

  initial begin
    logic [20:0] c;
    logic [31:0] md, mbus;
    logic [63:0] exp_alu;

    clr = 1'b1;
    drive(21'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_r2", {32'h0, R2}, 64'h0);
    chk("reset_z", Z, 64'h0);
    chk("reset_bus", {32'h0, bus_mux_out}, 64'h0);
    clr = 1'b0;

    // Directed sequences
    add_vec(M_READ | M_MDRIN, 32'd22, K_MDR, 64'd22, "load_mdr22");
    add_vec(M_MDROUT | M_R2IN, 32'd0, K_R2, 64'd22, "load_r2");
    add_vec(M_READ | M_MDRIN, 32'd24, K_NONE, 64'd0, "mdr24");
    add_vec(M_MDROUT | M_R4IN, 32'd0, K_R4, 64'd24, "load_r4");
    add_vec(M_READ | M_MDRIN, 32'd26, K_NONE, 64'd0, "mdr26");
    add_vec(M_MDROUT | M_R5IN, 32'd0, K_R5, 64'd26, "load_r5");
    add_vec(M_PCOUT | M_MARIN | M_INC | M_ZIN, 32'd0, K_Z, 64'd1, "fetch_inc");
    add_vec(M_ZLO | M_PCIN, 32'd0, K_NONE, 64'd0, "pc_load");
    add_vec(M_PCOUT, 32'd0, K_BUS, 64'd1, "pc_is_1");
    add_vec(M_READ | M_MDRIN, 32'h4A92_0000, K_MDR, 64'h4A92_0000, "mdr_instr");
    add_vec(M_MDROUT | M_IRIN, 32'd0, K_IR, 64'h4A92_0000, "load_ir");
    add_vec(M_R2OUT | M_YIN, 32'd0, K_NONE, 64'd0, "y22");
    add_vec(M_R4OUT | M_DIV | M_ZIN, 32'd0, K_Z, DIV_EN ? {32'd22, 32'd0} : 64'd46, "div_22_24");
    add_vec(M_ZLO | M_LOIN, 32'd0, K_LO, DIV_EN ? 64'd0 : 64'd46, "lo_load");
    add_vec(M_ZHI | M_HIIN, 32'd0, K_HI, DIV_EN ? 64'd22 : 64'd0, "hi_load");
    add_vec(M_R2OUT | M_R2IN, 32'd0, K_R2, 64'd22, "self_load_r2");
    add_vec(M_READ | M_MDRIN, 32'hFFFF_FFFD, K_NONE, 64'd0, "mdr_m3");
    add_vec(M_MDROUT | M_YIN, 32'd0, K_NONE, 64'd0, "y_m3");
    add_vec(M_READ | M_MDRIN, 32'd7, K_NONE, 64'd0, "mdr7");
    add_vec(M_MDROUT | M_MUL | M_ZIN, 32'd0, K_Z, 64'hFFFF_FFFF_FFFF_FFEB, "mul_m3_7");
    add_vec(M_READ | M_MDRIN, 32'h8000_0000, K_NONE, 64'd0, "mdr_min");
    add_vec(M_MDROUT | M_YIN, 32'd0, K_NONE, 64'd0, "y_min");
    add_vec(M_MDROUT | M_MUL | M_ZIN, 32'd0, K_Z, 64'h4000_0000_0000_0000, "mul_min_sq");
    add_vec(M_READ | M_MDRIN, 32'hFFFF_FFFF, K_NONE, 64'd0, "mdr_ones");
    add_vec(M_MDROUT | M_INC | M_ZIN, 32'd0, K_Z, 64'd0, "inc_wrap");
    add_vec(M_READ | M_MDRIN, 32'd5, K_NONE, 64'd0, "mdr5");
    add_vec(M_MDROUT | M_YIN, 32'd0, K_NONE, 64'd0, "y5");
    add_vec(M_DIV | M_ZIN, 32'd0, K_Z, DIV_EN ? {32'd5, 32'hFFFF_FFFF} : 64'd5, "div_by_0");
    add_vec(M_MDROUT | M_R2OUT, 32'd0, K_BUS, 64'd5, "bus_prio");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].mdat);
      #4;
      if (vecs[i].kind == K_BUS) chk(vecs[i].name, observe(K_BUS), vecs[i].exp);
      @(posedge clk);
      #1;
      if (vecs[i].kind != K_BUS && vecs[i].kind != K_NONE)
        chk(vecs[i].name, observe(vecs[i].kind), vecs[i].exp);
      $display("vec %0d %s ctl=%h obs=%h", i, vecs[i].name, vecs[i].ctl, observe(vecs[i].kind));
    end

    chk("fixed_regs_zero",
        {32'h0, R0 | R1 | R3 | R6 | R7 | R8 | R9 | R10 | R11 | R12 | R13 | R14 | R15}, 64'h0);

    // Asynchronous clear in mid-cycle, observed before any clock edge
    drive(M_PCOUT, 32'h0);
    clr = 1'b1;
    #1;
    chk("aclr_r2", {32'h0, R2}, 64'h0);
    chk("aclr_r5", {32'h0, R5}, 64'h0);
    chk("aclr_ir", {32'h0, IR}, 64'h0);
    chk("aclr_mdr", {32'h0, MDR}, 64'h0);
    chk("aclr_hi", {32'h0, Hi}, 64'h0);
    chk("aclr_z", Z, 64'h0);
    chk("aclr_bus_pc", {32'h0, bus_mux_out}, 64'h0);
    chk("aclr_alu_y", ALUout, 64'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0;
    m_hi = '0; m_lo = '0; m_r2 = '0; m_r4 = '0; m_r5 = '0; m_z = '0;

    for (int n = 0; n < 400; n++) begin
      c = '0;
      for (int b = 0; b < 6; b++)   c[b] = ($urandom_range(3) == 0);
      for (int b = 6; b < 17; b++)  c[b] = ($urandom_range(2) == 0);
      for (int b = 17; b < 20; b++) c[b] = ($urandom_range(3) == 0);
      c[20] = $urandom_range(1) == 1;
      case ($urandom_range(7))
        0: md = 32'h0;
        1: md = 32'hFFFF_FFFF;
        2: md = 32'h8000_0000;
        3: md = 32'h1;
        default: md = $urandom;
      endcase

      if (c[3])      mbus = m_mdr;
      else if (c[0]) mbus = m_pc;
      else if (c[1]) mbus = m_z[31:0];
      else if (c[2]) mbus = m_z[63:32];
      else if (c[4]) mbus = m_r2;
      else if (c[5]) mbus = m_r4;
      else           mbus = 32'h0;

      // The quotient of INT_MIN / -1 is unrepresentable; keep it out of the stream.
      if (m_y == 32'h8000_0000 && mbus == 32'hFFFF_FFFF) c[19] = 1'b0;
      exp_alu = ref_alu(m_y, mbus, c[19], c[18], c[17]);

      drive(c, md);
      #4;
      chk("rnd_bus", {32'h0, bus_mux_out}, {32'h0, mbus});
      chk("rnd_alu", ALUout, exp_alu);
      @(posedge clk);
      #1;

      if (c[6])  m_pc  = mbus;
      if (c[7])  m_mar = mbus;
      if (c[8])  m_mdr = c[20] ? md : mbus;
      if (c[9])  m_ir  = mbus;
      if (c[10]) m_y   = mbus;
      if (c[11]) m_z   = exp_alu;
      if (c[12]) m_hi  = mbus;
      if (c[13]) m_lo  = mbus;
      if (c[14]) m_r2  = mbus;
      if (c[15]) m_r4  = mbus;
      if (c[16]) m_r5  = mbus;

      chk("rnd_r2", {32'h0, R2}, {32'h0, m_r2});
      chk("rnd_r4", {32'h0, R4}, {32'h0, m_r4});
      chk("rnd_r5", {32'h0, R5}, {32'h0, m_r5});
      chk("rnd_ir", {32'h0, IR}, {32'h0, m_ir});
      chk("rnd_mdr", {32'h0, MDR}, {32'h0, m_mdr});
      chk("rnd_z", Z, m_z);
      chk("rnd_hi", {32'h0, Hi}, {32'h0, m_hi});
      chk("rnd_lo", {32'h0, Lo}, {32'h0, m_lo});
      $display("rnd %0d ctl=%h md=%h bus=%h alu=%h", n, c, md, mbus, exp_alu);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
